key_debouncer: RTL



---
 rtl/key_debouncer.sv | 118 +++++++++++
 1 files changed

// File: rtl/key_debouncer.sv
// Push-button conditioning: 2-FF synchroniser plus per-key debounce FSM
// producing a clean pressed level and one-cycle press/release pulses.
module key_debouncer #(
  parameter int KEYS          = 3,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic            clk100_i,
  input  logic            rst_i,
  input  logic [KEYS-1:0] key_i,
  output logic [KEYS-1:0] key_pressed_o,
  output logic [KEYS-1:0] key_press_o,
  output logic [KEYS-1:0] key_release_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [KEYS-1:0] sync1_q;
  logic [KEYS-1:0] key_s;

  // Reset to all ones so a released key looks idle right after reset
  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '1;
      key_s   <= '1;
    end else begin
      sync1_q <= key_i;
      key_s   <= sync1_q;
    end
  end

  for (genvar k = 0; k < KEYS; k++) begin : g_key
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pressed_d, press_d, release_d;

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pressed_d = key_pressed_o[k];
      press_d   = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
        RELEASED: begin
          if (!key_s[k]) begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        PRESS_WAIT: begin
          if (key_s[k]) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = PRESSED;
            cnt_d     = '0;
            pressed_d = 1'b1;
            press_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (key_s[k]) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        RELEASE_WAIT: begin
          if (!key_s[k]) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = RELEASED;
            cnt_d     = '0;
            pressed_d = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk100_i or posedge rst_i) begin
      if (rst_i) begin
        state_q          <= RELEASED;
        cnt_q            <= '0;
        key_pressed_o[k] <= 1'b0;
        key_press_o[k]   <= 1'b0;
        key_release_o[k] <= 1'b0;
      end else begin
        state_q          <= state_d;
        cnt_q            <= cnt_d;
        key_pressed_o[k] <= pressed_d;
        key_press_o[k]   <= press_d;
        key_release_o[k] <= release_d;
      end
    end
  end

endmodule
